// File: rtl/anode_scan_driver.sv
// Time-multiplexed active-low anode scanner for a four-digit seven-segment display.
// Each digit slot opens with a dead-time blank, then drives one anode if that digit is unmasked.
module anode_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [3:0] digit_mask_i,
  output logic [3:0] anode_o,
  output logic [1:0] digit_idx_o,
  output logic       frame_start_o,
  output logic       frame_done_o,
  output logic [1:0] dbg_state_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = (DEAD_CYCLES > 0) ? CW'(DEAD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // With no dead time every slot opens directly in DRIVE.
  localparam state_t SLOT_ENTRY = (DEAD_CYCLES > 0) ? BLANK : DRIVE;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    anode_q, anode_d;
  logic          fs_q, fs_d;
  logic          fd_q, fd_d;

  // Outputs are registered from next-state values so they line up with the
  // counter/index of the cycle they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    fs_d    = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SLOT_ENTRY;
          cnt_d   = '0;
          idx_d   = 2'd0;
          fs_d    = 1'b1;
          mask_d  = digit_mask_i;
        end
        BLANK, DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = SLOT_ENTRY;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              fs_d   = 1'b1;
              mask_d = digit_mask_i;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == BLANK && cnt_q == DEAD_LAST) begin
              state_d = DRIVE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      endcase
    end

    fd_d = (state_d != IDLE) && (cnt_d == CNT_LAST) && (idx_d == 2'd3);

    if (state_d == DRIVE && mask_d[idx_d]) begin
      anode_d = ~(4'b0001 << idx_d);
    end else begin
      anode_d = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      mask_q  <= 4'b0000;
      anode_q <= 4'b1111;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      anode_q <= anode_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  assign anode_o       = anode_q;
  assign digit_idx_o   = idx_q;
  assign frame_start_o = fs_q;
  assign frame_done_o  = fd_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_anode_scan_driver.sv
// Directed bench for anode_scan_driver: a dead-time instance (8/2) and a zero-dead-time instance (2/0)
// compared cycle by cycle against expected {frame_start, frame_done, idx, anode} words.
module tb_anode_scan_driver;

  localparam logic [7:0] IDLE_W = 8'h0F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] mask = 4'b1111;
  logic [3:0] anode;
  logic [1:0] idx;
  logic       fs, fd;
  logic [1:0] dbg;

  logic       en_z = 1'b0;
  logic [3:0] mask_z = 4'b1111;
  logic [3:0] anode_z;
  logic [1:0] idx_z;
  logic       fs_z, fd_z;
  logic [1:0] dbg_z;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_z_q[$];
  logic [3:0] onecold[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  anode_scan_driver #(.REFRESH_DIV(8), .DEAD_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .digit_mask_i(mask),
    .anode_o(anode), .digit_idx_o(idx), .frame_start_o(fs), .frame_done_o(fd),
    .dbg_state_o(dbg)
  );

  anode_scan_driver #(.REFRESH_DIV(2), .DEAD_CYCLES(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .en_i(en_z), .digit_mask_i(mask_z),
    .anode_o(anode_z), .digit_idx_o(idx_z), .frame_start_o(fs_z), .frame_done_o(fd_z),
    .dbg_state_o(dbg_z)
  );

  // At most one anode low, every cycle, on both instances.
  always @(negedge clk) begin
    checks++;
    assert ($countones(~anode) <= 1) else begin
      errors++;
      $error("FAIL onehot_main observed=%b expected=at-most-one-low", anode);
    end
    checks++;
    assert ($countones(~anode_z) <= 1) else begin
      errors++;
      $error("FAIL onehot_zero observed=%b expected=at-most-one-low", anode_z);
    end
  end

  // First n cycles of a frame as seen by a slot of `div` cycles with `dead` blank cycles.
  task automatic push_frame(input int div, input int dead, input logic [3:0] m,
                            input int n, input bit to_z);
    int k;
    logic [7:0] w;
    k = 0;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < div; c++) begin
        if (k < n) begin
          w[7]   = (s == 0 && c == 0);
          w[6]   = (s == 3 && c == div - 1);
          w[5:4] = s[1:0];
          w[3:0] = (c >= dead && m[s]) ? onecold[s] : 4'b1111;
          if (to_z) exp_z_q.push_back(w);
          else exp_q.push_back(w);
        end
        k++;
      end
    end
  endtask

  task automatic push_idle(input int n, input bit to_z);
    for (int i = 0; i < n; i++) begin
      if (to_z) exp_z_q.push_back(IDLE_W);
      else exp_q.push_back(IDLE_W);
    end
  endtask

  task automatic run(input int n, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL %s_underflow observed=empty expected=entry", tag);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({fs, fd, idx, anode} === e) else begin
          errors++;
          $error("FAIL %s cyc=%0d observed fs/fd/idx/anode=%b expected=%b", tag, i,
                 {fs, fd, idx, anode}, e);
        end
      end
      if (exp_z_q.size() > 0) begin
        e = exp_z_q.pop_front();
        checks++;
        assert ({fs_z, fd_z, idx_z, anode_z} === e) else begin
          errors++;
          $error("FAIL %s_z cyc=%0d observed fs/fd/idx/anode=%b expected=%b", tag, i,
                 {fs_z, fd_z, idx_z, anode_z}, e);
        end
      end
    end
  endtask

  initial begin
    // Reset held three cycles with en=1 overridden.
    push_idle(3, 1'b0);
    run(3, "reset");
    checks++;
    assert (dbg === 2'd0) else begin
      errors++;
      $error("FAIL reset_state observed=%0d expected=0", dbg);
    end
    rst_n = 1'b1;

    // Rotation with full mask; frame_start follows the first edge after release.
    push_frame(8, 2, 4'b1111, 32, 1'b0);
    push_frame(8, 2, 4'b1111, 32, 1'b0);
    run(64, "rotate");

    // Masking: slots 1 and 3 stay dark, period unchanged.
    mask = 4'b0101;
    push_frame(8, 2, 4'b0101, 32, 1'b0);
    run(32, "masked");

    // Mid-frame mask change only lands at the next frame.
    mask = 4'b1111;
    push_frame(8, 2, 4'b1111, 32, 1'b0);
    run(12, "midmask_a");
    mask = 4'b0001;
    run(20, "midmask_b");
    push_frame(8, 2, 4'b0001, 32, 1'b0);
    run(32, "midmask_next");

    // Disable at counter 4 of slot 2, then restart from slot 0.
    mask = 4'b1111;
    push_frame(8, 2, 4'b1111, 21, 1'b0);
    run(21, "pre_disable");
    en = 1'b0;
    push_idle(3, 1'b0);
    run(3, "disabled");
    en = 1'b1;
    push_frame(8, 2, 4'b1111, 32, 1'b0);
    run(32, "reenable");

    // en dropped on the frame_done cycle: no following frame_start.
    en = 1'b0;
    push_idle(2, 1'b0);
    run(2, "drop_on_done");

    // Zero dead time: anode never all-ones while enabled.
    en_z = 1'b1;
    push_idle(16, 1'b0);
    push_frame(2, 0, 4'b1111, 8, 1'b1);
    push_frame(2, 0, 4'b1111, 8, 1'b1);
    run(16, "zero_dead");
    en_z = 1'b0;
    push_idle(1, 1'b0);
    push_idle(1, 1'b1);
    run(1, "zero_dead_off");

    checks++;
    assert (exp_q.size() == 0 && exp_z_q.size() == 0) else begin
      errors++;
      $error("FAIL leftover observed=%0d/%0d expected=0/0", exp_q.size(), exp_z_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/anode_scan_driver.md
Name: anode_scan_driver

Overview:
- Time-multiplexing driver that generates the active-low anode select consumed by the four-digit seven-segment decoder.
- Rotates one digit at a time in this order:
  - 1110: A
  - 1101: B
  - 1011: A+B
  - 0111: A-B
- Inserts dead time between digits to suppress ghosting, supports per-digit blanking, and emits frame markers.
- Sits between the board clock and the decoder's anode input. The anode output also drives the board's anode pins.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; must be >= 2.
- DEAD_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- en, input, 1: scan enable. Low forces idle with the display dark.
- digit_mask, input, 4: per-digit enable. Bit i=1 shows digit i; bit 0 is A (anode 1110), bit 3 is A-B (anode 0111).
- anode, output, 4: active-low digit select, one-cold or all ones.
- digit_idx, output, 2: index of the current slot, 0..3.
- frame_start, output, 1: one-cycle pulse on the first cycle of slot 0.
- frame_done, output, 1: one-cycle pulse on the last cycle of slot 3.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk. There is no asynchronous path.
- Reset values:
  - anode = 4'b1111
  - digit_idx = 0
  - frame_start = 0, frame_done = 0
  - slot counter = 0
  - internal mask register = 4'b0000
  - state = IDLE
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Slot counter: width $clog2(REFRESH_DIV). It counts 0..REFRESH_DIV-1 and wraps to 0. At the wrap, digit_idx increments modulo 4 (3 wraps to 0).
- State machine:
  - IDLE: anode=1111, counter=0, digit_idx=0. When en=1, go to BLANK on the next edge with counter=0 and idx=0.
  - BLANK: anode=1111 while counter < DEAD_CYCLES. When counter reaches DEAD_CYCLES-1, go to DRIVE. If DEAD_CYCLES=0, BLANK is skipped and each slot starts in DRIVE.
  - DRIVE: anode = ~(4'b0001 << digit_idx) when mask_q[digit_idx]=1, otherwise 1111. At counter=REFRESH_DIV-1, go to BLANK for the next index.
  - Any state with en=0 goes to IDLE on the next edge. A slot interrupted mid-way is discarded. Re-enable always restarts at slot 0 with a full dead time.
- Anode timing within a slot:
  - anode is all ones for exactly DEAD_CYCLES cycles.
  - anode is then active for exactly REFRESH_DIV-DEAD_CYCLES cycles.
  - At no time is more than one anode bit low.
  - The anode transitions directly 1111 -> one-cold -> 1111; it never goes one-cold -> one-cold.
- Mask sampling: mask_q is loaded from digit_mask on the same edge frame_start is asserted, i.e. on entry to slot 0. Changes to digit_mask mid-frame take effect at the next frame only.
- frame_start:
  - Asserted for one cycle with counter=0 and idx=0.
  - This includes the first slot after leaving IDLE.
- frame_done:
  - Asserted for one cycle with counter=REFRESH_DIV-1 and idx=3.
  - It is followed immediately by frame_start of the next frame if en stays 1.
- Frame period: exactly 4*REFRESH_DIV cycles while enabled.
- Simultaneous events:
  - rst_n=0 overrides en.
  - en falling on the frame_done cycle suppresses the following frame_start.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with en=1 and digit_mask=1111 -> anode=1111, idx=0, both pulses 0. Release -> frame_start on the 2nd cycle after release.
2. Rotation (REFRESH_DIV=8, DEAD_CYCLES=2, mask=1111, en=1) -> each slot is 2 cycles of 1111 then 6 cycles of the one-cold anode. Sequence is 1110, 1101, 1011, 0111, repeating. frame_done pulses every 32 cycles, and frame_start follows 1 cycle later.
3. Masking (same params, mask=0101) -> anode low only for 1110 and 1011. Slots 1 and 3 remain 1111 for all 8 cycles, and the frame period stays 32.
4. Mid-frame mask change: change mask 1111->0001 during slot 1 -> the current frame still drives slots 2 and 3. The next frame shows only 1110.
5. Disable mid-slot: drop en at counter=4 of slot 2 -> next edge anode=1111 and idx=0. Re-assert en -> frame_start, then 2 dead cycles, then 1110.
6. Zero dead time (DEAD_CYCLES=0, REFRESH_DIV=2) -> the anode is never 1111 while enabled with mask=1111. Each digit is active 2 cycles, and the one-hot invariant is checked by assertion every cycle.
